// File: rtl/rotary_apply_if.sv
// Rotary-index-to-video-parameter bundle between a rotary decoder / vsync source and rotary_apply.
// Ports: counter_i, vs_i (source -> applier), index_o, value_o, changed_o, osd_o (applier -> consumer).
// The master modport is the driving side; the slave modport is the rotary_apply block.
interface rotary_apply_if #(
    parameter int N = 12,
    parameter int W = 8
);
    localparam int CW = $clog2(N);

    logic [CW-1:0] counter_i;
    logic          vs_i;
    logic [CW-1:0] index_o;
    logic [W-1:0]  value_o;
    logic          changed_o;
    logic          osd_o;

    modport master (
        output counter_i, vs_i,
        input  index_o, value_o, changed_o, osd_o
    );

    modport slave (
        input  counter_i, vs_i,
        output index_o, value_o, changed_o, osd_o
    );
endinterface

// File: rtl/rotary_apply.sv
// Purpose: slews a position index toward the decoder count once per frame and maps it to a saturated W-bit value.
// Latency: counter_i -> target 1 cycle; index/value update on the edge that first samples vs_i high; osd_o one edge later.
// Backpressure: none; counter_i is sampled every cycle and vs_i is edge-detected, nothing stalls upstream.
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport): counter_i, vs_i in; index_o, value_o, changed_o, osd_o out.
module rotary_apply #(
    parameter int N    = 12,
    parameter int INIT = 0,
    parameter int W    = 8,
    parameter int BASE = 0,
    parameter int STEP = 16,
    parameter int SLEW = 1,
    parameter int HOLD = 120
) (
    input  logic           clk_i,
    input  logic           rst_i,
    rotary_apply_if.slave  bus
);
    localparam int CW = $clog2(N);
    localparam int AW = W + CW + 1;
    // A zero HOLD still needs a one-bit register; it simply never leaves 0.
    localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    localparam logic [CW-1:0] MAX_IDX  = CW'(N - 1);
    localparam logic [CW-1:0] INIT_IDX = CW'(INIT);

    // BASE + idx*STEP in a width that cannot wrap, clipped to the all-ones W-bit value.
    function automatic logic [W-1:0] sat_value(input logic [CW-1:0] idx);
        logic [AW-1:0] raw;
        raw = AW'(BASE) + AW'(idx) * AW'(STEP);
        if (raw > AW'({W{1'b1}}))
            return {W{1'b1}};
        else
            return raw[W-1:0];
    endfunction

    logic [CW-1:0] tgt_q;
    logic [CW-1:0] index_q;
    logic [W-1:0]  value_q;
    logic          changed_q;
    logic          osd_q;
    logic [HW-1:0] hold_q;
    logic          vs_r;

    logic          fs;
    logic [CW-1:0] tgt_clamped;
    logic [CW-1:0] diff;
    logic [CW-1:0] idx_nxt;
    logic          idx_chg;

    assign fs          = bus.vs_i & ~vs_r;
    assign tgt_clamped = (bus.counter_i > MAX_IDX) ? MAX_IDX : bus.counter_i;

    // Step toward the registered target by at most SLEW; landing exactly on
    // the target when it is closer than SLEW keeps the index from overshooting.
    always_comb begin
        idx_nxt = index_q;
        diff    = '0;
        if (fs) begin
            if (tgt_q > index_q) begin
                diff    = tgt_q - index_q;
                idx_nxt = (int'(diff) > SLEW) ? index_q + CW'(SLEW) : tgt_q;
            end else if (tgt_q < index_q) begin
                diff    = index_q - tgt_q;
                idx_nxt = (int'(diff) > SLEW) ? index_q - CW'(SLEW) : tgt_q;
            end
        end
    end

    assign idx_chg = (idx_nxt != index_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tgt_q     <= INIT_IDX;
            index_q   <= INIT_IDX;
            value_q   <= sat_value(INIT_IDX);
            changed_q <= 1'b0;
            osd_q     <= 1'b0;
            hold_q    <= '0;
            // Start "high" so a vsync already asserted at release is not a frame start.
            vs_r      <= 1'b1;
        end else begin
            vs_r      <= bus.vs_i;
            tgt_q     <= tgt_clamped;
            index_q   <= idx_nxt;
            changed_q <= idx_chg;
            if (idx_chg)
                value_q <= sat_value(idx_nxt);
            if (idx_chg)
                hold_q <= HW'(HOLD);
            else if (fs && (hold_q != '0))
                hold_q <= hold_q - 1'b1;
            // Follows hold one edge late: rises the edge after a change and
            // falls the edge after the count reaches zero.
            osd_q     <= (hold_q != '0);
        end
    end

    assign bus.index_o   = index_q;
    assign bus.value_o   = value_q;
    assign bus.changed_o = changed_q;
    assign bus.osd_o     = osd_q;
endmodule

// File: tb/tb_rotary_apply.sv
// Directed bench for rotary_apply: dut_a (STEP=16, SLEW=1, HOLD=3) and dut_b (STEP=32, SLEW=3, HOLD=120).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
// Ends with a single pass/total summary line.
module tb_rotary_apply;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    rotary_apply_if #(.N(12), .W(8)) bus_a ();
    rotary_apply_if #(.N(12), .W(8)) bus_b ();

    rotary_apply #(
        .N(12), .INIT(0), .W(8), .BASE(0), .STEP(16), .SLEW(1), .HOLD(3)
    ) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    rotary_apply #(
        .N(12), .INIT(0), .W(8), .BASE(0), .STEP(32), .SLEW(3), .HOLD(120)
    ) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic vs_rise(input bit sel_b);
        if (sel_b) bus_b.vs_i = 1'b1;
        else       bus_a.vs_i = 1'b1;
        tick();
    endtask

    task automatic vs_fall(input bit sel_b);
        if (sel_b) bus_b.vs_i = 1'b0;
        else       bus_a.vs_i = 1'b0;
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        // Reset with vsync already high and a pending index move on dut_a.
        rst             = 1'b1;
        bus_a.vs_i      = 1'b1;
        bus_b.vs_i      = 1'b1;
        bus_a.counter_i = 4'd5;
        bus_b.counter_i = 4'd0;
        tick();
        tick();
        check("rst_index",   bus_a.index_o,   0);
        check("rst_value",   bus_a.value_o,   0);
        check("rst_changed", bus_a.changed_o, 0);
        check("rst_osd",     bus_a.osd_o,     0);
        check("rst_value_b", bus_b.value_o,   0);

        // Release with vsync high: no frame start, index must stay put.
        rst = 1'b0;
        tick();
        tick();
        check("hi_at_release_index",   bus_a.index_o,   0);
        check("hi_at_release_changed", bus_a.changed_o, 0);
        bus_a.vs_i = 1'b0;
        bus_b.vs_i = 1'b0;
        tick();
        check("after_vs_fall_index", bus_a.index_o, 0);

        // One index step per frame, SLEW=1, toward target 5.
        for (int i = 1; i <= 5; i++) begin
            vs_rise(1'b0);
            check($sformatf("slew_index_%0d", i), bus_a.index_o,   i);
            check($sformatf("slew_value_%0d", i), bus_a.value_o,   16 * i);
            check($sformatf("slew_chg_%0d", i),   bus_a.changed_o, 1);
            vs_fall(1'b0);
            check($sformatf("slew_chg_low_%0d", i), bus_a.changed_o, 0);
            check($sformatf("slew_osd_%0d", i),     bus_a.osd_o,     1);
        end
        // Sixth frame: already at target; hold 3 -> 2.
        vs_rise(1'b0);
        check("settled_index",   bus_a.index_o,   5);
        check("settled_changed", bus_a.changed_o, 0);
        vs_fall(1'b0);
        // Hold 2 -> 1, then 1 -> 0; osd falls the edge after the third fs.
        vs_rise(1'b0);
        vs_fall(1'b0);
        check("osd_hold_1", bus_a.osd_o, 1);
        vs_rise(1'b0);
        check("osd_at_third_fs", bus_a.osd_o, 1);
        vs_fall(1'b0);
        check("osd_expired", bus_a.osd_o, 0);

        // A change during the hold reloads the counter.
        bus_a.counter_i = 4'd6;
        tick();
        vs_rise(1'b0);
        check("reload_index6", bus_a.index_o, 6);
        vs_fall(1'b0);
        check("reload_osd_on", bus_a.osd_o, 1);
        vs_rise(1'b0);
        vs_fall(1'b0);
        bus_a.counter_i = 4'd7;
        tick();
        vs_rise(1'b0);
        check("reload_index7", bus_a.index_o, 7);
        vs_fall(1'b0);
        vs_rise(1'b0);
        vs_fall(1'b0);
        vs_rise(1'b0);
        vs_fall(1'b0);
        check("reload_osd_still_on", bus_a.osd_o, 1);
        vs_rise(1'b0);
        check("reload_osd_at_third_fs", bus_a.osd_o, 1);
        vs_fall(1'b0);
        check("reload_osd_off", bus_a.osd_o, 0);

        // Counter change coincident with fs: old target (9) is used this frame.
        bus_a.counter_i = 4'd9;
        tick();
        bus_a.counter_i = 4'd2;
        vs_rise(1'b0);
        check("coincident_index", bus_a.index_o,   8);
        check("coincident_value", bus_a.value_o,   128);
        check("coincident_chg",   bus_a.changed_o, 1);
        vs_fall(1'b0);
        vs_rise(1'b0);
        check("next_frame_index", bus_a.index_o, 7);
        check("next_frame_value", bus_a.value_o, 112);
        vs_fall(1'b0);

        // dut_b: out-of-range input clamps to 11, SLEW=3, STEP=32 saturates.
        bus_b.counter_i = 4'd15;
        tick();
        vs_rise(1'b1);
        check("b_index_3", bus_b.index_o, 3);
        check("b_value_3", bus_b.value_o, 96);
        vs_fall(1'b1);
        check("b_osd_on", bus_b.osd_o, 1);
        vs_rise(1'b1);
        check("b_index_6", bus_b.index_o, 6);
        check("b_value_6", bus_b.value_o, 192);
        vs_fall(1'b1);
        vs_rise(1'b1);
        check("b_index_9", bus_b.index_o, 9);
        check("b_value_9_sat", bus_b.value_o, 255);
        vs_fall(1'b1);
        vs_rise(1'b1);
        check("b_index_11", bus_b.index_o, 11);
        check("b_value_11_sat", bus_b.value_o, 255);
        check("b_chg_last_step", bus_b.changed_o, 1);
        vs_fall(1'b1);
        vs_rise(1'b1);
        check("b_index_hold", bus_b.index_o, 11);
        check("b_chg_none", bus_b.changed_o, 0);
        vs_fall(1'b1);

        // Reset coincident with an fs that would step 7 -> 6.
        rst        = 1'b1;
        bus_a.vs_i = 1'b1;
        tick();
        check("rst_fs_index",   bus_a.index_o,   0);
        check("rst_fs_value",   bus_a.value_o,   0);
        check("rst_fs_changed", bus_a.changed_o, 0);
        check("rst_fs_osd",     bus_a.osd_o,     0);
        check("rst_fs_index_b", bus_b.index_o,   0);
        rst = 1'b0;
        tick();
        check("post_rst_index",   bus_a.index_o,   0);
        check("post_rst_changed", bus_a.changed_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
